// File: rtl/mem_stage_sram.sv
// MEM stage of the ARM pipeline: services LDR/STR through a fixed-latency
// word SRAM, stalls upstream stages while an access is in flight, and holds
// the MEM/WB pipeline register.
module mem_stage_sram #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_IN,
  input  logic              MEM_R_EN_IN,
  input  logic              MEM_W_EN_IN,
  input  logic [31:0]       ALU_result_IN,
  input  logic [31:0]       ST_val_IN,
  input  logic [3:0]        Dest_IN,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we_n,
  input  logic [31:0]       sram_rdata,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_result,
  output logic [3:0]        Dest
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              is_read;
  logic [31:0]       hold;
  logic              req;
  logic [ADDR_W-1:0] word_addr;

  // Any memory request; a read wins when both are set.
  assign req = MEM_R_EN_IN | MEM_W_EN_IN;

  // Byte address relative to the SRAM window, converted to a wrapping word index.
  assign word_addr = ADDR_W'((ALU_result_IN - 32'(BASE_ADDR)) >> 2);

  // Stall upstream from the request cycle through the last access cycle; reset forces it low.
  assign freeze = ~rst & (((state == IDLE) & req) | (state == ACCESS));

  // SRAM access sequencer: latch the request, strobe for WAIT_CYCLES, capture read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_read    <= 1'b0;
      hold       <= '0;
      sram_we_n  <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr  <= word_addr;
            sram_wdata <= ST_val_IN;
            is_read    <= MEM_R_EN_IN;
            sram_we_n  <= MEM_R_EN_IN;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            if (is_read) begin
              hold <= sram_rdata;
            end
            sram_we_n <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          sram_we_n <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          sram_we_n <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB pipeline register: advance when not frozen, otherwise inject a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      ALU_result <= '0;
      MEM_result <= '0;
      Dest       <= '0;
    end else if (freeze) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
    end else begin
      WB_EN      <= WB_EN_IN;
      MEM_R_EN   <= MEM_R_EN_IN;
      ALU_result <= ALU_result_IN;
      Dest       <= Dest_IN;
      if (MEM_R_EN_IN) begin
        MEM_result <= hold;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: directed scenarios followed by random
// ALU/load/store traffic, checked against a word-addressed memory model.
module tb_mem_stage_sram;

  localparam int unsigned BASE = 1024;
  localparam int unsigned WAITC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_in, st_val_in;
  logic [3:0]  dest_in;
  logic        freeze;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we_n;
  logic [31:0] sram_rdata;
  logic        wb_en, mem_r_en;
  logic [31:0] alu_result, mem_result;
  logic [3:0]  dest;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_mr = 32'h0;

  // SRAM device model: combinational read, write on clock edge while strobe low
  bit [31:0] sram_mem [0:65535];
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;

  always #5 clk = ~clk;

  mem_stage_sram #(.BASE_ADDR(BASE), .ADDR_W(16), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(wb_en_in), .MEM_R_EN_IN(mem_r_en_in), .MEM_W_EN_IN(mem_w_en_in),
    .ALU_result_IN(alu_in), .ST_val_IN(st_val_in), .Dest_IN(dest_in),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we_n(sram_we_n), .sram_rdata(sram_rdata),
    .WB_EN(wb_en), .MEM_R_EN(mem_r_en), .ALU_result(alu_result),
    .MEM_result(mem_result), .Dest(dest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Word index of a byte address: offset from base, divided by 4, modulo 2^16
  function automatic int unsigned word_of(input logic [31:0] a);
    longint diff;
    diff = longint'(a) - longint'(BASE);
    if (diff < 0) diff += 64'sd4294967296;
    return int'((diff / 4) % 65536);
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // kind: 0 ALU, 1 load, 2 store, 3 load+store. Entered and left just after a rising edge.
  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] sv,
                       input logic [3:0] d, input logic wb);
    int fcount = 0;
    int wlow = 0;
    int cyc = 0;
    bit was_frozen = 0;
    bit finished = 0;
    bit rd = (kind == 1) || (kind == 3);
    bit wr = (kind == 2);
    int unsigned w = word_of(a);
    wb_en_in = wb; alu_in = a; st_val_in = sv; dest_in = d;
    mem_r_en_in = (kind == 1) || (kind == 3);
    mem_w_en_in = (kind == 2) || (kind == 3);
    if (kind == 0) begin
      @(negedge clk);
      chk("alu_freeze", freeze, 0);
      @(posedge clk); #1;
    end else begin
      while (!finished && cyc < 20) begin
        @(negedge clk);
        if (was_frozen) chk("bubble", {wb_en, mem_r_en}, 0);
        if (freeze) begin
          fcount++;
          if (!sram_we_n) wlow++;
          if (fcount > 1) begin
            chk("sram_addr", sram_addr, w);
            chk("sram_wdata", sram_wdata, sv);
          end
        end else if (fcount > 0) begin
          chk("done_we_n", sram_we_n, 1);
          finished = 1;
        end
        was_frozen = freeze;
        @(posedge clk); #1;
        cyc++;
      end
      if (!finished) chk("timeout", 0, 1);
      chk("freeze_len", fcount, WAITC + 1);
      chk("we_low_len", wlow, wr ? WAITC : 0);
      if (wr) ref_mem[w] = sv;
      if (rd) exp_mr = ref_read(w);
    end
    chk("wb_en", wb_en, wb);
    chk("mem_r_en", mem_r_en, rd);
    chk("alu_result", alu_result, a);
    chk("dest", dest, d);
    chk("mem_result", mem_result, exp_mr);
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    rst = 1'b1;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_in = 0; st_val_in = 0; dest_in = 0;
    #12;
    chk("rst_freeze", freeze, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_outs", {wb_en, mem_r_en, dest}, 0);
    chk("rst_alu", alu_result, 0);
    chk("rst_mr", mem_result, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain ALU op
    do_op(0, 32'h55, 32'h0, 4'd3, 1'b1);
    // Store, then load of the same word, then load+store back-to-back
    do_op(2, 32'd1032, 32'hDEADBEEF, 4'd0, 1'b0);
    chk("str_addr", sram_addr, 2);
    do_op(1, 32'd1032, 32'h0, 4'd5, 1'b1);
    chk("ldr_data", mem_result, 32'hDEADBEEF);
    do_op(1, 32'd1036, 32'h0, 4'd6, 1'b1);
    do_op(2, 32'd1036, 32'hCAFEF00D, 4'd0, 1'b0);
    // Both requests: read only, address wraps below base
    do_op(3, 32'd1020, 32'h12345678, 4'd7, 1'b1);
    chk("wrap_addr", sram_addr, 16'hFFFF);
    do_op(1, 32'd1020, 32'h0, 4'd8, 1'b1);
    chk("wrap_no_write", mem_result, 32'h0);

    // Reset in the middle of a store access
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 1;
    alu_in = 32'd1064; st_val_in = 32'hA5A5F00F; dest_in = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_we_n", sram_we_n, 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_freeze", freeze, 0);
    chk("abort_wb_en", wb_en, 0);
    chk("abort_mr", mem_result, 0);
    ref_mem[word_of(32'd1064)] = 32'hA5A5F00F;
    exp_mr = 32'h0;
    mem_w_en_in = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(1, 32'd1064, 32'h0, 4'd9, 1'b1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(BASE + $urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      do_op(kind, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
